// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, EX/MEM and MEM/WB operand forwarding, and load-use detection.
// Optional feature macro: FORWARDING_EN (undefined -> operands come from the registered register-file values only).
module id_ex_stage #(
    parameter int BITS_SIZE  = 32,
    parameter int BITS_SHAMT = 5,
    parameter int BITS_REG   = 5,
    parameter int BITS_FUNCT = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [BITS_SIZE-1:0]  i_data_a,
    input  logic [BITS_SIZE-1:0]  i_data_b,
    input  logic [BITS_SIZE-1:0]  i_imm,
    input  logic [BITS_SHAMT-1:0] i_shamt,
    input  logic [BITS_FUNCT-1:0] i_funct,
    input  logic [BITS_REG-1:0]   i_rs,
    input  logic [BITS_REG-1:0]   i_rt,
    input  logic [BITS_REG-1:0]   i_rd,
    input  logic                  i_alu_src,
    input  logic                  i_flag_shamt,
    input  logic                  i_reg_dst,
    input  logic                  i_reg_write,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic                  i_mem_to_reg,
    input  logic                  i_exmem_reg_write,
    input  logic [BITS_REG-1:0]   i_exmem_rd,
    input  logic [BITS_SIZE-1:0]  i_exmem_result,
    input  logic                  i_memwb_reg_write,
    input  logic [BITS_REG-1:0]   i_memwb_rd,
    input  logic [BITS_SIZE-1:0]  i_memwb_result,
    output logic                  o_valid,
    output logic [BITS_SIZE-1:0]  o_alu_a,
    output logic [BITS_SIZE-1:0]  o_alu_b,
    output logic [BITS_SHAMT-1:0] o_alu_shamt,
    output logic                  o_flag_shamt,
    output logic [BITS_FUNCT-1:0] o_alu_op,
    output logic [BITS_SIZE-1:0]  o_store_data,
    output logic [BITS_REG-1:0]   o_write_reg,
    output logic                  o_reg_write,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_to_reg,
    output logic                  o_load_use
);

    logic                  valid_q,      valid_d;
    logic [BITS_SIZE-1:0]  data_a_q,     data_a_d;
    logic [BITS_SIZE-1:0]  data_b_q,     data_b_d;
    logic [BITS_SIZE-1:0]  imm_q,        imm_d;
    logic [BITS_SHAMT-1:0] shamt_q,      shamt_d;
    logic [BITS_FUNCT-1:0] funct_q,      funct_d;
    logic [BITS_REG-1:0]   rs_q,         rs_d;
    logic [BITS_REG-1:0]   rt_q,         rt_d;
    logic [BITS_REG-1:0]   write_reg_q,  write_reg_d;
    logic                  alu_src_q,    alu_src_d;
    logic                  flag_shamt_q, flag_shamt_d;
    logic                  reg_write_q,  reg_write_d;
    logic                  mem_read_q,   mem_read_d;
    logic                  mem_write_q,  mem_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;

    // Flush beats stall so a held instruction can be discarded into a bubble.
    always_comb begin
        valid_d      = valid_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        imm_d        = imm_q;
        shamt_d      = shamt_q;
        funct_d      = funct_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        write_reg_d  = write_reg_q;
        alu_src_d    = alu_src_q;
        flag_shamt_d = flag_shamt_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (i_flush) begin
            valid_d      = 1'b0;
            data_a_d     = '0;
            data_b_d     = '0;
            imm_d        = '0;
            shamt_d      = '0;
            funct_d      = '0;
            rs_d         = '0;
            rt_d         = '0;
            write_reg_d  = '0;
            alu_src_d    = 1'b0;
            flag_shamt_d = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else if (!i_stall) begin
            valid_d      = i_valid;
            data_a_d     = i_data_a;
            data_b_d     = i_data_b;
            imm_d        = i_imm;
            shamt_d      = i_shamt;
            funct_d      = i_funct;
            rs_d         = i_rs;
            rt_d         = i_rt;
            write_reg_d  = i_reg_dst ? i_rd : i_rt;
            alu_src_d    = i_valid & i_alu_src;
            flag_shamt_d = i_valid & i_flag_shamt;
            reg_write_d  = i_valid & i_reg_write;
            mem_read_d   = i_valid & i_mem_read;
            mem_write_d  = i_valid & i_mem_write;
            mem_to_reg_d = i_valid & i_mem_to_reg;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            data_a_q     <= '0;
            data_b_q     <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            funct_q      <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            write_reg_q  <= '0;
            alu_src_q    <= 1'b0;
            flag_shamt_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            imm_q        <= imm_d;
            shamt_q      <= shamt_d;
            funct_q      <= funct_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            write_reg_q  <= write_reg_d;
            alu_src_q    <= alu_src_d;
            flag_shamt_q <= flag_shamt_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    logic [BITS_SIZE-1:0] fwd_a;
    logic [BITS_SIZE-1:0] fwd_b;

`ifdef FORWARDING_EN
    logic exmem_hit_a, exmem_hit_b, memwb_hit_a, memwb_hit_b;

    // $0 is hardwired zero, so a write targeting it must never be forwarded.
    assign exmem_hit_a = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == rs_q);
    assign exmem_hit_b = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == rt_q);
    assign memwb_hit_a = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == rs_q);
    assign memwb_hit_b = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == rt_q);

    always_comb begin
        fwd_a = data_a_q;
        if (exmem_hit_a)      fwd_a = i_exmem_result;
        else if (memwb_hit_a) fwd_a = i_memwb_result;
        fwd_b = data_b_q;
        if (exmem_hit_b)      fwd_b = i_exmem_result;
        else if (memwb_hit_b) fwd_b = i_memwb_result;
    end
`else
    logic unused_fwd_inputs;

    assign unused_fwd_inputs = ^{i_exmem_reg_write, i_exmem_rd, i_exmem_result,
                                 i_memwb_reg_write, i_memwb_rd, i_memwb_result};
    assign fwd_a = data_a_q;
    assign fwd_b = data_b_q;
`endif

    assign o_valid      = valid_q;
    assign o_alu_a      = fwd_a;
    assign o_alu_b      = alu_src_q ? imm_q : fwd_b;
    assign o_store_data = fwd_b;
    assign o_alu_shamt  = shamt_q;
    assign o_flag_shamt = flag_shamt_q;
    assign o_alu_op     = funct_q;
    assign o_write_reg  = write_reg_q;
    assign o_reg_write  = reg_write_q;
    assign o_mem_read   = mem_read_q;
    assign o_mem_write  = mem_write_q;
    assign o_mem_to_reg = mem_to_reg_q;

    assign o_load_use = valid_q && mem_read_q && (write_reg_q != '0) && i_valid &&
                        ((write_reg_q == i_rs) || (write_reg_q == i_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expected values are hand-computed and follow FORWARDING_EN when it is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_valid = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
    logic [31:0] i_data_a = '0, i_data_b = '0, i_imm = '0;
    logic [4:0]  i_shamt = '0;
    logic [5:0]  i_funct = '0;
    logic [4:0]  i_rs = '0, i_rt = '0, i_rd = '0;
    logic        i_alu_src = 1'b0, i_flag_shamt = 1'b0, i_reg_dst = 1'b0, i_reg_write = 1'b0;
    logic        i_mem_read = 1'b0, i_mem_write = 1'b0, i_mem_to_reg = 1'b0;
    logic        i_exmem_reg_write = 1'b0, i_memwb_reg_write = 1'b0;
    logic [4:0]  i_exmem_rd = '0, i_memwb_rd = '0;
    logic [31:0] i_exmem_result = '0, i_memwb_result = '0;

    logic        o_valid, o_flag_shamt, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_load_use;
    logic [31:0] o_alu_a, o_alu_b, o_store_data;
    logic [4:0]  o_alu_shamt, o_write_reg;
    logic [5:0]  o_alu_op;

    int total = 0;
    int bad = 0;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_imm(i_imm), .i_shamt(i_shamt), .i_funct(i_funct),
        .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_alu_src(i_alu_src), .i_flag_shamt(i_flag_shamt),
        .i_reg_dst(i_reg_dst), .i_reg_write(i_reg_write), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
        .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd(i_exmem_rd), .i_exmem_result(i_exmem_result),
        .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_rd(i_memwb_rd), .i_memwb_result(i_memwb_result),
        .o_valid(o_valid), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_shamt(o_alu_shamt),
        .o_flag_shamt(o_flag_shamt), .o_alu_op(o_alu_op), .o_store_data(o_store_data),
        .o_write_reg(o_write_reg), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_load_use(o_load_use)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Load a nonzero instruction so reset has something to clear.
        i_valid = 1'b1; i_funct = 6'b100000; i_data_a = 32'd5; i_data_b = 32'd7;
        i_rs = 5'd1; i_rt = 5'd2; i_rd = 5'd3; i_reg_dst = 1'b1; i_reg_write = 1'b1;
        i_mem_read = 1'b1; i_mem_write = 1'b1; i_mem_to_reg = 1'b1; i_flag_shamt = 1'b1; i_shamt = 5'd4;
        tick();
        check("preload_valid", {31'd0, o_valid}, 32'd1);

        // Async reset asserted mid-cycle; exmem targets rs=1 but registered rs is cleared.
        #2;
        i_exmem_reg_write = 1'b1; i_exmem_rd = 5'd1; i_exmem_result = 32'hDEAD;
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_alu_a", o_alu_a, 32'd0);
        check("rst_alu_b", o_alu_b, 32'd0);
        check("rst_store", o_store_data, 32'd0);
        check("rst_alu_op", {26'd0, o_alu_op}, 32'd0);
        check("rst_shamt", {27'd0, o_alu_shamt}, 32'd0);
        check("rst_write_reg", {27'd0, o_write_reg}, 32'd0);
        check("rst_ctrl", {27'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_flag_shamt}, 32'd0);
        check("rst_load_use", {31'd0, o_load_use}, 32'd0);

        // Release mid-cycle, first edge loads normally.
        @(negedge clk);
        rst_n = 1'b1;
        i_exmem_reg_write = 1'b0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_to_reg = 1'b0; i_flag_shamt = 1'b0;
        tick();
        check("post_rst_op", {26'd0, o_alu_op}, 32'h20);
        check("post_rst_a", o_alu_a, 32'd5);
        check("post_rst_b", o_alu_b, 32'd7);
        check("post_rst_valid", {31'd0, o_valid}, 32'd1);
        check("post_rst_wreg", {27'd0, o_write_reg}, 32'd3);

        // Stall holds, stall+flush bubbles the held instruction.
        i_data_a = 32'd3;
        tick();
        check("load_a3", o_alu_a, 32'd3);
        i_stall = 1'b1; i_data_a = 32'd9;
        tick();
        check("stall_hold_a", o_alu_a, 32'd3);
        i_flush = 1'b1;
        tick();
        check("flush_valid", {31'd0, o_valid}, 32'd0);
        check("flush_ctrl", {28'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg}, 32'd0);
        check("flush_a", o_alu_a, 32'd0);
        check("flush_op", {26'd0, o_alu_op}, 32'd0);
        check("flush_wreg", {27'd0, o_write_reg}, 32'd0);

        // Forwarding priority on rs=8.
        i_stall = 1'b0; i_flush = 1'b0;
        i_rs = 5'd8; i_rt = 5'd2; i_data_a = 32'h100; i_data_b = 32'h200;
        tick();
        i_exmem_reg_write = 1'b1; i_exmem_rd = 5'd8; i_exmem_result = 32'h11;
        i_memwb_reg_write = 1'b1; i_memwb_rd = 5'd8; i_memwb_result = 32'h22;
        #1;
        check("fwd_both_a", o_alu_a, FWD ? 32'h11 : 32'h100);
        check("fwd_both_b_nohit", o_alu_b, 32'h200);
        i_exmem_reg_write = 1'b0;
        #1;
        check("fwd_memwb_a", o_alu_a, FWD ? 32'h22 : 32'h100);

        // rs=0 is never forwarded even with matching rd=0 writes.
        i_rs = 5'd0;
        tick();
        i_exmem_reg_write = 1'b1; i_exmem_rd = 5'd0; i_memwb_rd = 5'd0;
        #1;
        check("fwd_r0_a", o_alu_a, 32'h100);

        // Immediate selects B; store data still forwarded rt.
        i_alu_src = 1'b1; i_imm = 32'hFFFF_FFFC; i_rt = 5'd4; i_data_b = 32'h44;
        tick();
        i_exmem_reg_write = 1'b1; i_exmem_rd = 5'd4; i_exmem_result = 32'h55;
        i_memwb_reg_write = 1'b0;
        #1;
        check("imm_alu_b", o_alu_b, 32'hFFFF_FFFC);
        check("store_fwd", o_store_data, FWD ? 32'h55 : 32'h44);

        // Load-use detection.
        i_exmem_reg_write = 1'b0;
        i_alu_src = 1'b0; i_reg_dst = 1'b0; i_rt = 5'd9; i_mem_read = 1'b1; i_valid = 1'b1;
        tick();
        check("lw_wreg", {27'd0, o_write_reg}, 32'd9);
        i_rs = 5'd9; i_rt = 5'd0;
        #1;
        check("load_use_hit", {31'd0, o_load_use}, 32'd1);
        i_valid = 1'b0;
        #1;
        check("load_use_id_invalid", {31'd0, o_load_use}, 32'd0);
        i_valid = 1'b1; i_rs = 5'd0; i_rt = 5'd9;
        #1;
        check("load_use_rt_hit", {31'd0, o_load_use}, 32'd1);
        i_rt = 5'd0;
        tick();
        i_rs = 5'd0; i_rt = 5'd0;
        #1;
        check("load_use_r0", {31'd0, o_load_use}, 32'd0);

        // Invalid instruction captures control as zero.
        i_valid = 1'b0; i_reg_write = 1'b1; i_mem_write = 1'b1; i_rt = 5'd6;
        tick();
        check("invalid_valid", {31'd0, o_valid}, 32'd0);
        check("invalid_ctrl", {29'd0, o_reg_write, o_mem_read, o_mem_write}, 32'd0);
        check("invalid_wreg", {27'd0, o_write_reg}, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core, directly upstream of the EX-stage ALU. It registers decoded operands and control from ID and applies stall and flush. It resolves EX/MEM and MEM/WB forwarding onto the ALU operand buses. It flags load-use hazards to the hazard unit.

## Interface
- BITS_SIZE, 32, datapath width
- BITS_SHAMT, 5, shift-amount width
- BITS_REG, 5, register-index width
- BITS_FUNCT, 6, ALU function code width (R-type funct encoding)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  ID holds a real instruction
- i_stall / i_flush  in  1 each  hold stage / insert bubble
- i_data_a, i_data_b  in  BITS_SIZE  register-file rs / rt values
- i_imm  in  BITS_SIZE  sign-extended immediate
- i_shamt  in  BITS_SHAMT; i_funct  in  BITS_FUNCT
- i_rs, i_rt, i_rd  in  BITS_REG  register indices
- i_alu_src, i_flag_shamt, i_reg_dst, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1 each  decoded control
- i_exmem_reg_write  in  1; i_exmem_rd  in  BITS_REG; i_exmem_result  in  BITS_SIZE
- i_memwb_reg_write  in  1; i_memwb_rd  in  BITS_REG; i_memwb_result  in  BITS_SIZE
- o_valid  out  1  stage holds a real instruction
- o_alu_a, o_alu_b  out  BITS_SIZE  ALU operands (forwarded)
- o_alu_shamt  out  BITS_SHAMT; o_flag_shamt  out  1; o_alu_op  out  BITS_FUNCT
- o_store_data  out  BITS_SIZE  forwarded rt value for SW
- o_write_reg  out  BITS_REG  destination (rd if reg_dst else rt)
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1 each
- o_load_use  out  1  load-use hazard against the instruction in ID

## Operation
- Register update priority per rising edge: reset > i_flush > i_stall > load.
- Load: capture all i_* payload. o_write_reg is captured as i_reg_dst ? i_rd : i_rt. valid is captured from i_valid. When i_valid=0, all control bits are captured as 0.
- Stall: all registers hold.
- Flush (bubble): valid=0. All control=0. All data, index and funct fields=0. o_alu_op=0 (SLL) with zero operands gives ALU result 0.
- Forwarding for each source (rs→A, rt→B/store), evaluated in priority order:
  - EX/MEM hit: i_exmem_reg_write=1, i_exmem_rd≠0, i_exmem_rd equals the registered index → use i_exmem_result.
  - Else MEM/WB hit (same rule on memwb_*) → use i_memwb_result.
  - Else use the registered register-file value.
  - Register $0 is never forwarded.
- o_alu_a = forwarded rs.
- o_alu_b = registered alu_src ? registered imm : forwarded rt.
- o_store_data is always forwarded rt, independent of alu_src.
- o_load_use = o_valid & o_mem_read & (o_write_reg≠0) & i_valid & (o_write_reg==i_rs | o_write_reg==i_rt).
  - The hazard unit responds by stalling PC/IF/ID and flushing this stage for one cycle.

## Timing
- Latency: one cycle from ID inputs to registered outputs.
- Forwarding muxes and o_load_use are combinational on the registered state and the same-cycle i_exmem_*/i_memwb_*/i_rs/i_rt.
- Asynchronous reset (i_rst_n=0) clears every register immediately. During reset, every output is 0: o_valid, all control, o_alu_a/b, o_store_data, o_alu_op, o_alu_shamt, o_write_reg, o_load_use.
- Reset deasserted mid-stream: the first edge after release loads normally.
- i_flush and i_stall asserted together → bubble.
- Flush while holding a stalled instruction discards that instruction.
- Both forward sources hit → EX/MEM wins.

## Configuration
- FORWARDING_EN defined: forwarding as above.
- FORWARDING_EN undefined:
  - o_alu_a, o_alu_b (rt path) and o_store_data use registered values only.
  - i_exmem_*/i_memwb_* ports remain present but are ignored.
  - o_load_use is unchanged.

## Test plan
- Reset: hold i_rst_n=0 mid-clock with nonzero inputs → all outputs 0 immediately; first edge after release with funct=6'b100000, a=5, b=7 → o_alu_op=6'b100000, o_alu_a=5, o_alu_b=7, o_valid=1.
- Stall/flush: load a=3; assert i_stall with new a=9 → o_alu_a stays 3; assert i_stall+i_flush → o_valid=0, all control 0, o_alu_a=0.
- Forward priority: registered rs=8; exmem rd=8/result=0x11 and memwb rd=8/result=0x22, both reg_write=1 → o_alu_a=0x11; drop exmem reg_write → 0x22. Repeat with rs=0 → registered value passed, no forwarding.
- Immediate/store: alu_src=1, imm=0xFFFFFFFC, rt=4 with exmem rd=4/result=0x55 → o_alu_b=0xFFFFFFFC, o_store_data=0x55.
- Load-use: stage holds LW with mem_read=1, write_reg=9; ID presents i_rs=9, i_valid=1 → o_load_use=1. Change to i_rs=i_rt=0 with write_reg=0 → o_load_use=0.
- Macro off: repeat forward-priority scenario without FORWARDING_EN → o_alu_a equals registered i_data_a.
